// File: rtl/calc_pkg.sv
// Shared types for the calculator port adapter: core command/response
// encodings, per-tag lifecycle states and the channel FSM states.
package calc_pkg;

  localparam int RESP_W = 2;

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } calc_cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE    = 2'd0,
    RESP_OK      = 2'd1,
    RESP_OVF     = 2'd2,
    RESP_INVALID = 2'd3
  } calc_resp_e;

  // TAG_ISSUING covers the window between accept and op2 issue: the tag is
  // no longer FREE but a core response for it is not yet legitimate.
  typedef enum logic [1:0] {
    TAG_FREE        = 2'd0,
    TAG_ISSUING     = 2'd1,
    TAG_OUTSTANDING = 2'd2,
    TAG_DONE        = 2'd3
  } tag_state_e;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_SEND1 = 2'd1,
    CH_SEND2 = 2'd2
  } chan_state_e;

endpackage

// File: rtl/calc_port_chan.sv
// One adapter channel: request FSM, tag table with saturating timeout
// timers, and a response FIFO sized to the tag pool (so it cannot overflow).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. Valid never depends on ready; the source holds its payload stable
// while valid && !ready. dn_* therefore stays fixed until popped.
module calc_port_chan
  import calc_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CMD_W   = 4,
  parameter int TAG_W   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CMD_W-1:0]  up_cmd,
  input  logic [DATA_W-1:0] up_op1,
  input  logic [DATA_W-1:0] up_op2,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [RESP_W-1:0] dn_resp,
  output logic              dn_timeout,
  output logic [DATA_W-1:0] dn_data,
  output logic [TAG_W-1:0]  dn_tag,
  output logic [CMD_W-1:0]  core_cmd,
  output logic [DATA_W-1:0] core_data,
  output logic [TAG_W-1:0]  core_tag,
  input  logic [RESP_W-1:0] core_resp,
  input  logic [DATA_W-1:0] core_rdata,
  input  logic [TAG_W-1:0]  core_rtag,
  output logic              err_spurious,
  output logic [1:0]        dbg_state
);

  localparam int NTAGS = 2 ** TAG_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [TAG_W-1:0] PTR_ONE = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_ONE = (TAG_W + 1)'(1);

  chan_state_e state_q, state_d;
  logic              rdy_en_q;
  logic [TAG_W-1:0]  cur_tag_q;
  logic [DATA_W-1:0] op2_q;
  logic [CMD_W-1:0]  cmd_d;
  logic [DATA_W-1:0] data_d;
  logic [TAG_W-1:0]  tag_d;

  logic [NTAGS-1:0][1:0]       tag_st;
  logic [NTAGS-1:0][TMR_W-1:0] timer;

  logic             any_free, to_hit, accept;
  logic [TAG_W-1:0] alloc_tag, to_tag;

  logic              rsp_hit, spur, push, pop;
  logic [TAG_W-1:0]  push_tag, pop_tag;
  logic [RESP_W-1:0] push_resp;
  logic [DATA_W-1:0] push_data;
  logic              push_to;

  logic [NTAGS-1:0][RESP_W-1:0] fifo_resp;
  logic [NTAGS-1:0][DATA_W-1:0] fifo_data;
  logic [NTAGS-1:0][TAG_W-1:0]  fifo_tag;
  logic [NTAGS-1:0]             fifo_to;
  logic [TAG_W-1:0]             wr_ptr, rd_ptr;
  logic [TAG_W:0]               count;

  // Lowest FREE tag for allocation, lowest expired OUTSTANDING tag for timeout.
  always_comb begin
    any_free  = 1'b0;
    alloc_tag = '0;
    to_hit    = 1'b0;
    to_tag    = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (tag_st[i] == TAG_FREE) begin
        any_free  = 1'b1;
        alloc_tag = TAG_W'(i);
      end
      if (tag_st[i] == TAG_OUTSTANDING && timer[i] == TMR_MAX) begin
        to_hit = 1'b1;
        to_tag = TAG_W'(i);
      end
    end
  end

  assign up_ready  = rdy_en_q && any_free && (state_q == CH_IDLE || state_q == CH_SEND2);
  assign accept    = up_valid && up_ready;
  assign dbg_state = state_q;

  // A genuine core response takes the single push slot ahead of any timeout.
  assign rsp_hit   = (core_resp != '0) && (tag_st[core_rtag] == TAG_OUTSTANDING);
  assign spur      = (core_resp != '0) && !rsp_hit;
  assign push      = rsp_hit || to_hit;
  assign push_tag  = rsp_hit ? core_rtag : to_tag;
  assign push_resp = rsp_hit ? core_resp : '0;
  assign push_data = rsp_hit ? core_rdata : '0;
  assign push_to   = !rsp_hit;

  assign dn_valid   = (count != '0);
  assign pop        = dn_valid && dn_ready;
  assign pop_tag    = fifo_tag[rd_ptr];
  assign dn_resp    = dn_valid ? fifo_resp[rd_ptr] : '0;
  assign dn_data    = dn_valid ? fifo_data[rd_ptr] : '0;
  assign dn_tag     = dn_valid ? fifo_tag[rd_ptr] : '0;
  assign dn_timeout = dn_valid && fifo_to[rd_ptr];

  // Channel FSM next state and next core-side drive values.
  always_comb begin
    state_d = state_q;
    cmd_d   = '0;
    data_d  = '0;
    tag_d   = '0;
    case (state_q)
      CH_IDLE:  if (accept) state_d = CH_SEND1;
      CH_SEND1: begin
        state_d = CH_SEND2;
        data_d  = op2_q;
        tag_d   = cur_tag_q;
      end
      CH_SEND2: state_d = accept ? CH_SEND1 : CH_IDLE;
      default:  state_d = CH_IDLE;
    endcase
    if (accept) begin
      cmd_d  = up_cmd;
      data_d = up_op1;
      tag_d  = alloc_tag;
    end
  end

  // FSM state, registered core outputs, captured request and spurious pulse.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CH_IDLE;
      rdy_en_q     <= 1'b0;
      core_cmd     <= '0;
      core_data    <= '0;
      core_tag     <= '0;
      cur_tag_q    <= '0;
      op2_q        <= '0;
      err_spurious <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= 1'b1;
      core_cmd     <= cmd_d;
      core_data    <= data_d;
      core_tag     <= tag_d;
      err_spurious <= spur;
      if (accept) begin
        cur_tag_q <= alloc_tag;
        op2_q     <= up_op2;
      end
    end
  end

  // Tag lifecycle FREE -> ISSUING -> OUTSTANDING -> DONE -> FREE, plus timers.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      tag_st <= '0;
      timer  <= '0;
    end else begin
      for (int i = 0; i < NTAGS; i++) begin
        if (tag_st[i] == TAG_OUTSTANDING && timer[i] != TMR_MAX) timer[i] <= timer[i] + TMR_ONE;
      end
      if (accept) tag_st[alloc_tag] <= TAG_ISSUING;
      if (state_q == CH_SEND1) begin
        tag_st[cur_tag_q] <= TAG_OUTSTANDING;
        timer[cur_tag_q]  <= '0;
      end
      if (push) tag_st[push_tag] <= TAG_DONE;
      if (pop)  tag_st[pop_tag]  <= TAG_FREE;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  // Response FIFO storage; contents are masked by dn_valid so need no reset.
  always_ff @(posedge c_clk) begin
    if (push) begin
      fifo_resp[wr_ptr] <= push_resp;
      fifo_data[wr_ptr] <= push_data;
      fifo_tag[wr_ptr]  <= push_tag;
      fifo_to[wr_ptr]   <= push_to;
    end
  end

endmodule

// File: rtl/calc_port_adapter.sv
// N-channel adapter between request/response streams and the calculator
// core ports; each channel is an independent calc_port_chan on its bus slice.
module calc_port_adapter
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int CMD_W     = 4,
  parameter int TAG_W     = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          up_valid,
  output logic [NUM_PORTS-1:0]          up_ready,
  input  logic [NUM_PORTS*CMD_W-1:0]    up_cmd,
  input  logic [NUM_PORTS*DATA_W-1:0]   up_op1,
  input  logic [NUM_PORTS*DATA_W-1:0]   up_op2,
  output logic [NUM_PORTS-1:0]          dn_valid,
  input  logic [NUM_PORTS-1:0]          dn_ready,
  output logic [NUM_PORTS*RESP_W-1:0]   dn_resp,
  output logic [NUM_PORTS-1:0]          dn_timeout,
  output logic [NUM_PORTS*DATA_W-1:0]   dn_data,
  output logic [NUM_PORTS*TAG_W-1:0]    dn_tag,
  output logic [NUM_PORTS*CMD_W-1:0]    core_cmd,
  output logic [NUM_PORTS*DATA_W-1:0]   core_data,
  output logic [NUM_PORTS*TAG_W-1:0]    core_tag,
  input  logic [NUM_PORTS*RESP_W-1:0]   core_resp,
  input  logic [NUM_PORTS*DATA_W-1:0]   core_rdata,
  input  logic [NUM_PORTS*TAG_W-1:0]    core_rtag,
  output logic [NUM_PORTS-1:0]          err_spurious,
  output logic [NUM_PORTS*2-1:0]        dbg_state
);

  // One channel per port, each wired to its own slice of every bus.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
    calc_port_chan #(
      .DATA_W (DATA_W),
      .CMD_W  (CMD_W),
      .TAG_W  (TAG_W),
      .TIMEOUT(TIMEOUT)
    ) u_chan (
      .c_clk       (c_clk),
      .reset       (reset),
      .up_valid    (up_valid[i]),
      .up_ready    (up_ready[i]),
      .up_cmd      (up_cmd[i*CMD_W +: CMD_W]),
      .up_op1      (up_op1[i*DATA_W +: DATA_W]),
      .up_op2      (up_op2[i*DATA_W +: DATA_W]),
      .dn_valid    (dn_valid[i]),
      .dn_ready    (dn_ready[i]),
      .dn_resp     (dn_resp[i*RESP_W +: RESP_W]),
      .dn_timeout  (dn_timeout[i]),
      .dn_data     (dn_data[i*DATA_W +: DATA_W]),
      .dn_tag      (dn_tag[i*TAG_W +: TAG_W]),
      .core_cmd    (core_cmd[i*CMD_W +: CMD_W]),
      .core_data   (core_data[i*DATA_W +: DATA_W]),
      .core_tag    (core_tag[i*TAG_W +: TAG_W]),
      .core_resp   (core_resp[i*RESP_W +: RESP_W]),
      .core_rdata  (core_rdata[i*DATA_W +: DATA_W]),
      .core_rtag   (core_rtag[i*TAG_W +: TAG_W]),
      .err_spurious(err_spurious[i]),
      .dbg_state   (dbg_state[i*2 +: 2])
    );
  end

endmodule
